// File: rtl/global_mem_mp.sv
// rtl/global_mem_mp.sv - multi-port AXI4 slave memory model over one shared word array
// Purpose: N_PORTS AXI4 slave ports share a single DATA_W-wide array. Each port
//   has its own AR and AW command FIFO. One read engine and one write engine each
//   serve the ports round-robin, return IDs, and flag DECERR or SLVERR.
// Ports: clk, rst (synchronous, active-high). The AR, R, AW, W and B channels are
//   flattened per port: port p occupies slice [p*W +: W] of each bus.

module global_mem_mp_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wp_q, rp_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rp_q];
    assign do_pop  = pop_i && !empty_o;
    // A full FIFO can still take a push in the cycle it is popped.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wp_q] <= data_i;
                wp_q        <= wp_q + 1'b1;
            end
            if (do_pop) begin
                rp_q <= rp_q + 1'b1;
            end
            cnt_q <= cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end
endmodule

module global_mem_mp #(
    parameter int          N_PORTS        = 2,
    parameter int          ADDR_W         = 32,
    parameter int          DATA_W         = 64,
    parameter int          ID_W           = 4,
    parameter int          MEM_ADDR_W     = 12,
    parameter logic [63:0] ADDR_OFFSET    = 64'h1000_0000,
    parameter int          RD_LATENCY     = 2,
    parameter int          CMD_FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_PORTS*ADDR_W-1:0]    s_araddr,
    input  logic [N_PORTS*8-1:0]         s_arlen,
    input  logic [N_PORTS*ID_W-1:0]      s_arid,
    input  logic [N_PORTS-1:0]           s_arvalid,
    output logic [N_PORTS-1:0]           s_arready,
    output logic [N_PORTS*DATA_W-1:0]    s_rdata,
    output logic [N_PORTS*2-1:0]         s_rresp,
    output logic [N_PORTS*ID_W-1:0]      s_rid,
    output logic [N_PORTS-1:0]           s_rlast,
    output logic [N_PORTS-1:0]           s_rvalid,
    input  logic [N_PORTS-1:0]           s_rready,
    input  logic [N_PORTS*ADDR_W-1:0]    s_awaddr,
    input  logic [N_PORTS*8-1:0]         s_awlen,
    input  logic [N_PORTS*ID_W-1:0]      s_awid,
    input  logic [N_PORTS-1:0]           s_awvalid,
    output logic [N_PORTS-1:0]           s_awready,
    input  logic [N_PORTS*DATA_W-1:0]    s_wdata,
    input  logic [N_PORTS*DATA_W/8-1:0]  s_wstrb,
    input  logic [N_PORTS-1:0]           s_wlast,
    input  logic [N_PORTS-1:0]           s_wvalid,
    output logic [N_PORTS-1:0]           s_wready,
    output logic [N_PORTS*2-1:0]         s_bresp,
    output logic [N_PORTS*ID_W-1:0]      s_bid,
    output logic [N_PORTS-1:0]           s_bvalid,
    input  logic [N_PORTS-1:0]           s_bready
);
    localparam int BYTES = DATA_W / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int PW    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam int CW    = ADDR_W + 8 + ID_W;   // FIFO entry: {addr, len, id}

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_BURST} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;

    // Memory is deliberately never reset so its contents survive rst.
    logic [DATA_W-1:0] mem [2**MEM_ADDR_W];

    logic [CW-1:0]      ar_head [N_PORTS];
    logic [CW-1:0]      aw_head [N_PORTS];
    logic [N_PORTS-1:0] ar_full, ar_empty, ar_pop, aw_full, aw_empty, aw_pop;

    // Returns {decerr, word index}. Beats beyond the start simply wrap the index.
    function automatic logic [MEM_ADDR_W:0] decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] off;
        logic              err;
        off = addr - ADDR_W'(ADDR_OFFSET);
        err = (addr < ADDR_W'(ADDR_OFFSET)) || ((off >> (MEM_ADDR_W + BSH)) != '0);
        return {err, off[BSH +: MEM_ADDR_W]};
    endfunction

    // Picks the first requesting port at or after rr. The loop runs downward so
    // that the closest candidate is written last and therefore wins.
    function automatic logic [PW-1:0] rr_pick(input logic [N_PORTS-1:0] req,
                                              input logic [PW-1:0] rr);
        logic [PW-1:0] g;
        int            p;
        g = rr;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            p = (int'(rr) + i) % N_PORTS;
            if (req[p]) g = PW'(p);
        end
        return g;
    endfunction

    function automatic logic [PW-1:0] next_port(input logic [PW-1:0] g);
        return PW'((int'(g) + 1) % N_PORTS);
    endfunction

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        global_mem_mp_fifo #(.W(CW), .DEPTH(CMD_FIFO_DEPTH)) u_ar_fifo (
            .clk(clk), .rst(rst),
            .push_i(s_arvalid[p] && s_arready[p]),
            .data_i({s_araddr[p*ADDR_W +: ADDR_W], s_arlen[p*8 +: 8], s_arid[p*ID_W +: ID_W]}),
            .pop_i(ar_pop[p]), .data_o(ar_head[p]), .full_o(ar_full[p]), .empty_o(ar_empty[p])
        );
        global_mem_mp_fifo #(.W(CW), .DEPTH(CMD_FIFO_DEPTH)) u_aw_fifo (
            .clk(clk), .rst(rst),
            .push_i(s_awvalid[p] && s_awready[p]),
            .data_i({s_awaddr[p*ADDR_W +: ADDR_W], s_awlen[p*8 +: 8], s_awid[p*ID_W +: ID_W]}),
            .pop_i(aw_pop[p]), .data_o(aw_head[p]), .full_o(aw_full[p]), .empty_o(aw_empty[p])
        );
        // Ready is held low during reset so every handshake output reads 0 then.
        assign s_arready[p] = !ar_full[p] && !rst;
        assign s_awready[p] = !aw_full[p] && !rst;
    end

    // ---------------- read engine ----------------
    rd_state_t         rd_st_q, rd_st_d;
    logic [PW-1:0]     rd_port_q, rd_port_d, rr_rd_q, rr_rd_d, rd_grant;
    logic [MEM_ADDR_W-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]        rd_beat_q, rd_beat_d, rd_len_q, rd_len_d, rd_cnt_q, rd_cnt_d;
    logic [ID_W-1:0]   rd_id_q, rd_id_d;
    logic              rd_err_q, rd_err_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [CW-1:0]     ar_cmd;
    logic [MEM_ADDR_W:0] ar_dec;
    logic              rd_hs, rd_load;

    assign rd_grant = rr_pick(~ar_empty, rr_rd_q);
    assign ar_cmd   = ar_head[rd_grant];
    assign ar_dec   = decode(ar_cmd[CW-1 -: ADDR_W]);
    assign rd_hs    = rvalid_q && s_rready[rd_port_q];

    always_comb begin
        rd_st_d   = rd_st_q;
        rd_port_d = rd_port_q;
        rr_rd_d   = rr_rd_q;
        rd_idx_d  = rd_idx_q;
        rd_beat_d = rd_beat_q;
        rd_len_d  = rd_len_q;
        rd_cnt_d  = rd_cnt_q;
        rd_id_d   = rd_id_q;
        rd_err_d  = rd_err_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        ar_pop    = '0;
        rd_load   = 1'b0;
        case (rd_st_q)
            RD_IDLE: begin
                if (!(&ar_empty)) begin
                    ar_pop[rd_grant] = 1'b1;
                    rr_rd_d   = next_port(rd_grant);
                    rd_port_d = rd_grant;
                    rd_idx_d  = ar_dec[MEM_ADDR_W-1:0];
                    rd_err_d  = ar_dec[MEM_ADDR_W];
                    rd_len_d  = ar_cmd[ID_W +: 8];
                    rd_id_d   = ar_cmd[ID_W-1:0];
                    rd_beat_d = 8'd0;
                    rd_cnt_d  = 8'(RD_LATENCY - 1);
                    rd_st_d   = RD_WAIT;
                    rd_load   = (RD_LATENCY == 1);
                end
            end
            RD_WAIT: begin
                if (rd_cnt_q <= 8'd1) rd_load = 1'b1;
                else                  rd_cnt_d = rd_cnt_q - 8'd1;
            end
            RD_BURST: begin
                if (rd_hs) begin
                    if (rd_beat_q == rd_len_q) begin
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                        rd_st_d  = RD_IDLE;
                    end else begin
                        rd_beat_d = rd_beat_q + 8'd1;
                        rd_idx_d  = rd_idx_q + 1'b1;
                        rd_load   = 1'b1;
                    end
                end
            end
            default: rd_st_d = RD_IDLE;
        endcase
        // Loading a beat samples memory now, so a same-cycle write is not seen.
        if (rd_load) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_err_d ? '0 : mem[rd_idx_d];
            rlast_d  = (rd_beat_d == rd_len_d);
            rresp_d  = rd_err_d ? 2'b11 : 2'b00;
            rd_st_d  = RD_BURST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_st_q <= RD_IDLE;  rd_port_q <= '0;  rr_rd_q <= '0;  rd_idx_q <= '0;
            rd_beat_q <= '0;     rd_len_q <= '0;   rd_cnt_q <= '0; rd_id_q <= '0;
            rd_err_q <= 1'b0;    rvalid_q <= 1'b0; rlast_q <= 1'b0;
            rdata_q <= '0;       rresp_q <= '0;
        end else begin
            rd_st_q <= rd_st_d;     rd_port_q <= rd_port_d; rr_rd_q <= rr_rd_d;
            rd_idx_q <= rd_idx_d;   rd_beat_q <= rd_beat_d; rd_len_q <= rd_len_d;
            rd_cnt_q <= rd_cnt_d;   rd_id_q <= rd_id_d;     rd_err_q <= rd_err_d;
            rvalid_q <= rvalid_d;   rlast_q <= rlast_d;     rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end

    // ---------------- write engine ----------------
    wr_state_t         wr_st_q, wr_st_d;
    logic [PW-1:0]     wr_port_q, wr_port_d, rr_wr_q, rr_wr_d, wr_grant;
    logic [MEM_ADDR_W-1:0] wr_idx_q, wr_idx_d;
    logic [7:0]        wr_beat_q, wr_beat_d, wr_len_q, wr_len_d;
    logic [ID_W-1:0]   wr_id_q, wr_id_d;
    logic              wr_err_q, wr_err_d, wr_slv_q, wr_slv_d, bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [CW-1:0]     aw_cmd;
    logic [MEM_ADDR_W:0] aw_dec;
    logic              wr_hs, w_mism, mem_we;
    logic [DATA_W-1:0] w_data;
    logic [BYTES-1:0]  w_strb;

    assign wr_grant = rr_pick(~aw_empty, rr_wr_q);
    assign aw_cmd   = aw_head[wr_grant];
    assign aw_dec   = decode(aw_cmd[CW-1 -: ADDR_W]);
    assign wr_hs    = (wr_st_q == WR_DATA) && s_wvalid[wr_port_q];
    assign w_data   = s_wdata[wr_port_q*DATA_W +: DATA_W];
    assign w_strb   = s_wstrb[wr_port_q*BYTES +: BYTES];
    assign w_mism   = s_wlast[wr_port_q] != (wr_beat_q == wr_len_q);
    assign mem_we   = wr_hs && !wr_err_q && !rst;

    always_comb begin
        wr_st_d   = wr_st_q;
        wr_port_d = wr_port_q;
        rr_wr_d   = rr_wr_q;
        wr_idx_d  = wr_idx_q;
        wr_beat_d = wr_beat_q;
        wr_len_d  = wr_len_q;
        wr_id_d   = wr_id_q;
        wr_err_d  = wr_err_q;
        wr_slv_d  = wr_slv_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        aw_pop    = '0;
        case (wr_st_q)
            WR_IDLE: begin
                if (!(&aw_empty)) begin
                    aw_pop[wr_grant] = 1'b1;
                    rr_wr_d   = next_port(wr_grant);
                    wr_port_d = wr_grant;
                    wr_idx_d  = aw_dec[MEM_ADDR_W-1:0];
                    wr_err_d  = aw_dec[MEM_ADDR_W];
                    wr_len_d  = aw_cmd[ID_W +: 8];
                    wr_id_d   = aw_cmd[ID_W-1:0];
                    wr_beat_d = 8'd0;
                    wr_slv_d  = 1'b0;
                    wr_st_d   = WR_DATA;
                end
            end
            WR_DATA: begin
                if (wr_hs) begin
                    wr_slv_d = wr_slv_q || w_mism;
                    if (wr_beat_q == wr_len_q) begin
                        bvalid_d = 1'b1;
                        bresp_d  = (wr_slv_q || w_mism) ? 2'b10 : (wr_err_q ? 2'b11 : 2'b00);
                        wr_st_d  = WR_RESP;
                    end else begin
                        wr_beat_d = wr_beat_q + 8'd1;
                        wr_idx_d  = wr_idx_q + 1'b1;
                    end
                end
            end
            WR_RESP: begin
                if (s_bready[wr_port_q]) begin
                    bvalid_d = 1'b0;
                    wr_st_d  = WR_IDLE;
                end
            end
            default: wr_st_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_st_q <= WR_IDLE;  wr_port_q <= '0; rr_wr_q <= '0;  wr_idx_q <= '0;
            wr_beat_q <= '0;     wr_len_q <= '0;  wr_id_q <= '0;  wr_err_q <= 1'b0;
            wr_slv_q <= 1'b0;    bvalid_q <= 1'b0; bresp_q <= '0;
        end else begin
            wr_st_q <= wr_st_d;     wr_port_q <= wr_port_d; rr_wr_q <= rr_wr_d;
            wr_idx_q <= wr_idx_d;   wr_beat_q <= wr_beat_d; wr_len_q <= wr_len_d;
            wr_id_q <= wr_id_d;     wr_err_q <= wr_err_d;   wr_slv_q <= wr_slv_d;
            bvalid_q <= bvalid_d;   bresp_q <= bresp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (w_strb[b]) mem[wr_idx_q][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

    // ---------------- per-port outputs ----------------
    for (genvar p = 0; p < N_PORTS; p++) begin : g_out
        assign s_rvalid[p]                = rvalid_q && (rd_port_q == PW'(p));
        assign s_rlast[p]                 = rlast_q && (rd_port_q == PW'(p));
        assign s_rdata[p*DATA_W +: DATA_W] = rdata_q;
        assign s_rresp[p*2 +: 2]          = rresp_q;
        assign s_rid[p*ID_W +: ID_W]      = rd_id_q;
        assign s_wready[p]                = (wr_st_q == WR_DATA) && (wr_port_q == PW'(p));
        assign s_bvalid[p]                = bvalid_q && (wr_port_q == PW'(p));
        assign s_bresp[p*2 +: 2]          = bresp_q;
        assign s_bid[p*ID_W +: ID_W]      = wr_id_q;
    end
endmodule
